// File: rtl/uart_pkg.sv
// Shared UART constants, frame geometry and state encodings for the rx and tx sides.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // 50 MHz core clock, 19200 baud
    localparam int BAUD_DIV_DEF = 2604;
    localparam int HALF_DIV_DEF = BAUD_DIV_DEF / 2;

    // Baud and bit counter widths
    localparam int CNT_W     = 12;
    localparam int BIT_CNT_W = 4;

    // 8N1 frame: start + 8 data + stop, LSB first
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = DATA_BITS + 2;

    // Line level while no frame is in flight
    localparam logic LINE_IDLE = 1'b1;

    // Receiver states
    typedef enum logic {
        IDLE,
        RECEIVE
    } rx_state_t;

    // Transmitter states
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: synchronizes RX, samples each bit at its mid-point, presents the byte with rdy/frm_err.
// Latency: start edge to rdy is 2 + HALF_DIV + 9*BAUD_DIV + 1 cycles.
// Backpressure: none; rdy is a sticky flag, and a new frame overwrites rx_data whether or not it was consumed.
module uart_rcv
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 frm_err
);

    // Synchronizer and edge-detect history; all idle-high so reset never looks like a start edge
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    rx_state_t state;
    rx_state_t state_nxt;

    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_BITS:0]   shift_reg;
    logic [DATA_BITS:0]   shift_nxt;

    logic start_edge;
    logic sample;
    logic start_bad;
    logic last_sample;

    // A sample fires on the cycle the down-counter would reach zero, so the spacing is exactly BAUD_DIV
    assign start_edge  = (state == IDLE) && rx_prev && !rx_sync;
    assign sample      = (state == RECEIVE) && (baud_cnt <= CNT_W'(1));
    assign start_bad   = sample && (bit_cnt == '0) && rx_sync;
    assign last_sample = sample && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
    assign shift_nxt   = {rx_sync, shift_reg[DATA_BITS:1]};

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= LINE_IDLE;
            rx_sync <= LINE_IDLE;
            rx_prev <= LINE_IDLE;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: leave IDLE on a start edge, return on a rejected start bit or after the stop bit
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt = RECEIVE;
                end
            end
            RECEIVE: begin
                if (start_bad || last_sample) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Baud and bit counters: half-bit delay to the start mid-point, then one bit period per sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (start_edge) begin
            baud_cnt <= CNT_W'(HALF_DIV);
            bit_cnt  <= '0;
        end else if (sample && !start_bad) begin
            baud_cnt <= CNT_W'(BAUD_DIV);
            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
        end else if (state == RECEIVE && !sample) begin
            baud_cnt <= baud_cnt - CNT_W'(1);
        end
    end

    // Shift register: samples enter at the top, so after the stop bit the data sits in [7:0], LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '1;
        end else if (sample && !start_bad) begin
            shift_reg <= shift_nxt;
        end
    end

    // Output byte and framing status, updated only when a frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data <= '0;
            frm_err <= 1'b0;
        end else if (last_sample) begin
            rx_data <= shift_nxt[DATA_BITS-1:0];
            frm_err <= !rx_sync;
        end
    end

    // rdy: set on frame completion (wins over clr_rdy), cleared by the consumer or the next start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy <= 1'b0;
        end else if (last_sample) begin
            rdy <= 1'b1;
        end else if (start_edge || clr_rdy) begin
            rdy <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rcv.md
UART_RCV -- requirements
Module: uart_rcv

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clk cycles per bit (50 MHz / 19200 baud).
REQ-002 Parameter HALF_DIV, default BAUD_DIV/2 (1302), cycles from start-bit falling edge to start-bit mid-point.
REQ-003 clk  input  1  system clock, 50 MHz, all flops rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 RX  input  1  asynchronous serial line, idle high, 8N1 LSB-first.
REQ-006 clr_rdy  input  1  consumer acknowledge; clears rdy.
REQ-007 rx_data  output  8  last received byte.
REQ-008 rdy  output  1  byte available in rx_data.
REQ-009 frm_err  output  1  stop bit of last frame sampled low.

Function
REQ-010 RX SHALL pass through a 2-flop synchronizer, both flops preset to 1 by reset; all logic uses the synchronized value.
REQ-011 FSM SHALL have states IDLE and RECEIVE.
REQ-012 In IDLE, a falling edge (synced RX high->low) SHALL load the baud counter with HALF_DIV, clear bit count, clear rdy, and enter RECEIVE.
REQ-013 Baud counter SHALL be a 12-bit down-counter decrementing every cycle in RECEIVE; a sample SHALL occur when it reaches 0, reloading it with BAUD_DIV.
REQ-014 First sample (start bit mid-point) SHALL return FSM to IDLE with no other effect if synced RX is 1 (glitch rejection).
REQ-015 Each sample SHALL shift synced RX into bit 8 of a 9-bit right-shifting register and increment a 4-bit bit counter.
REQ-016 On the 10th sample (stop bit) FSM SHALL return to IDLE; rx_data SHALL equal shift register [7:0]; frm_err SHALL equal inverse of stop-bit sample.
REQ-017 rdy SHALL assert the cycle after the 10th sample and hold until clr_rdy or next valid start edge; set SHALL win over simultaneous clr_rdy.
REQ-018 A frame with frm_err=1 SHALL still assert rdy and update rx_data.
REQ-019 clr_rdy SHALL have no effect on rx_data, frm_err, or FSM.
REQ-020 rx_data SHALL hold its value between frames; a new frame overwrites it without regard to rdy (no overrun flag).
REQ-021 Falling edges during RECEIVE SHALL be ignored; edge detection is re-armed only in IDLE.
REQ-022 Start edge to rdy latency SHALL be 2 (sync) + HALF_DIV + 9*BAUD_DIV + ~2 cycles, within 4 cycles of 24740.

Reset
REQ-023 Reset SHALL force: FSM IDLE, rdy 0, frm_err 0, rx_data 8'h00, synchronizer flops 1, shift register 9'h1FF, counters 0.
REQ-024 Reset mid-frame SHALL abandon the frame; no rdy results from the partial frame after reset release.
REQ-025 First valid frame after reset release SHALL be received correctly with no dummy byte.

Structure
REQ-026 Shared package uart_pkg SHALL hold BAUD_DIV default, HALF_DIV, and the rx state typedef (IDLE, RECEIVE); uart_tx-side constants move there too.
REQ-027 Block SHALL be a single module; no sub-module; synchronizer inline.

Verification
REQ-028 Loopback: existing UART_tx sends 8'hA5 into RX -> rdy rises once, rx_data=8'hA5, frm_err=0 after ~24740 cycles.
REQ-029 Back-to-back bytes 8'h00, 8'hFF, 8'h5A with no idle gap, no clr_rdy -> rx_data sequence 00, FF, 5A; rdy clears at each start edge and re-asserts per byte.
REQ-030 RX low pulse of 500 cycles then high -> no rdy, FSM back to IDLE by cycle 1304 after edge; following frame 8'h3C received correctly.
REQ-031 Frame 8'h81 with stop bit driven low -> rdy=1, rx_data=8'h81, frm_err=1; next good frame clears frm_err.
REQ-032 clr_rdy pulsed in exact cycle rdy sets -> rdy=1; clr_rdy pulsed 10 cycles later -> rdy=0, rx_data unchanged.
REQ-033 rst_n asserted at bit 4 of frame 8'hC3, released 100 cycles later with RX high -> outputs at reset values, no rdy; next frame 8'h42 received correctly.
